// File: rtl/cdc_rx_fifo.sv
// cdc_rx_fifo: single-clock first-word-fall-through FIFO.
//
// The head entry is visible on pop_data whenever empty is low. A pop removes
// it at the next clock edge. When the FIFO is full, a push is accepted only
// if a pop happens in the same cycle. Push and pop together leave the count
// unchanged. pop_data reads zero while the FIFO is empty.
//
// Ports:
//   clk        - clock
//   rst_n      - asynchronous active-low reset; empties the FIFO
//   push       - write push_data this cycle
//   push_data  - entry to write
//   pop        - remove the head entry this cycle
//   pop_data   - head entry (FWFT)
//   full       - FIFO_DEPTH entries held
//   empty      - no entries held
module cdc_rx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW   = $clog2(DEPTH);
  localparam int CNTW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CNTW-1:0]  count;
  logic             push_en;
  logic             pop_en;

  assign empty   = (count == '0);
  assign full    = (count == CNTW'(DEPTH));
  assign pop_en  = pop && !empty;
  assign push_en = push && (!full || pop_en);

  // Masking the head while empty makes the outputs read zero after reset
  // without having to reset the storage array.
  assign pop_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_en) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop_en)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_en, pop_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/cdc_rx_mux.sv
// cdc_rx_mux: multi-channel receiver for toggle-handshake clock-domain
// crossings, merged into one output queue.
//
// Each channel's toggle passes through a DEPTH-stage synchroniser. Every flip
// seen at the synchroniser output captures that channel's held bus and marks
// the channel pending. A round-robin arbiter moves one pending capture per
// cycle into a FWFT FIFO as {channel, data}.
//
// Output handshake: dst_valid is high whenever the FIFO head holds an entry,
// and it depends only on registered state. The entry on dst_chan/dst_bus is
// consumed at the clock edge where dst_valid && dst_ready are both high. The
// head stays stable while dst_valid is high and dst_ready is low.
//
// Ports:
//   dst_clk          - the only clock; all state lives here
//   dst_rst_n        - asynchronous active-low reset
//   src_toggle       - one asynchronous toggle per channel
//   src_bus          - held data buses, channel k at [k*WIDTH +: WIDTH]
//   dst_valid        - FIFO head valid
//   dst_ready        - consumer accepts the head
//   dst_bus          - head data
//   dst_chan         - head channel index
//   dst_overrun      - sticky per-channel overrun flags
//   dst_overrun_clr  - clears all overrun flags
module cdc_rx_mux #(
  parameter int WIDTH      = 8,
  parameter int CHANNELS   = 4,
  parameter int DEPTH      = 3,
  parameter int FIFO_DEPTH = 4,
  localparam int CW        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                      dst_clk,
  input  logic                      dst_rst_n,
  input  logic [CHANNELS-1:0]       src_toggle,
  input  logic [CHANNELS*WIDTH-1:0] src_bus,
  output logic                      dst_valid,
  input  logic                      dst_ready,
  output logic [WIDTH-1:0]          dst_bus,
  output logic [CW-1:0]             dst_chan,
  output logic [CHANNELS-1:0]       dst_overrun,
  input  logic                      dst_overrun_clr
);

  logic [DEPTH-1:0]    pipe [CHANNELS];
  logic [WIDTH-1:0]    cap  [CHANNELS];
  logic [CHANNELS-1:0] pending;
  logic [CHANNELS-1:0] sync_event;
  logic [CHANNELS-1:0] grant_vec;
  logic [CHANNELS-1:0] ovr_set;
  logic [CW-1:0]       last;
  logic [CW-1:0]       grant_idx;
  logic                grant_any;

  logic                fifo_full;
  logic                fifo_empty;
  logic                pop;
  logic                push_ok;
  logic [CW+WIDTH-1:0] push_data;
  logic [CW+WIDTH-1:0] head;

  // A flip is seen where the two oldest synchroniser stages disagree.
  always_comb begin
    sync_event = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      sync_event[k] = pipe[k][DEPTH-1] != pipe[k][DEPTH-2];
    end
  end

  assign dst_valid = !fifo_empty;
  assign pop       = dst_valid && dst_ready;
  // A full FIFO can still take an entry when the head leaves this cycle.
  assign push_ok   = !fifo_full || pop;

  // Round-robin: scan from last+1 and wrap, first pending channel wins.
  always_comb begin
    logic [CW-1:0] idx;
    grant_any = 1'b0;
    grant_idx = '0;
    idx       = '0;
    for (int i = 1; i <= CHANNELS; i++) begin
      idx = CW'((int'(last) + i) % CHANNELS);
      if (!grant_any && push_ok && pending[idx]) begin
        grant_any = 1'b1;
        grant_idx = idx;
      end
    end
  end

  assign grant_vec = grant_any ? (CHANNELS'(1) << grant_idx) : '0;
  assign push_data = {grant_idx, cap[grant_idx]};

  // Overwriting an ungranted capture loses the older value. When the same
  // channel is granted in that cycle, the older value is already on its way
  // into the FIFO, so nothing is lost.
  assign ovr_set = sync_event & pending & ~grant_vec;

  always_ff @(posedge dst_clk or negedge dst_rst_n) begin
    if (!dst_rst_n) begin
      for (int k = 0; k < CHANNELS; k++) begin
        pipe[k] <= '0;
        cap[k]  <= '0;
      end
      pending     <= '0;
      dst_overrun <= '0;
      last        <= CW'(CHANNELS - 1);
    end else begin
      for (int k = 0; k < CHANNELS; k++) begin
        pipe[k] <= {pipe[k][DEPTH-2:0], src_toggle[k]};
        if (sync_event[k]) begin
          cap[k]     <= src_bus[k*WIDTH +: WIDTH];
          pending[k] <= 1'b1;
        end else if (grant_vec[k]) begin
          pending[k] <= 1'b0;
        end
      end
      // A new overrun wins over a simultaneous clear.
      dst_overrun <= ovr_set | (dst_overrun & ~{CHANNELS{dst_overrun_clr}});
      if (grant_any) begin
        last <= grant_idx;
      end
    end
  end

  cdc_rx_fifo #(
    .WIDTH (CW + WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (dst_clk),
    .rst_n     (dst_rst_n),
    .push      (grant_any),
    .push_data (push_data),
    .pop       (pop),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign dst_bus  = head[WIDTH-1:0];
  assign dst_chan = head[WIDTH +: CW];

endmodule

// File: doc/cdc_rx_mux.md
# cdc_rx_mux

Multi-channel receive side for toggle-handshake clock-domain crossings. Each channel carries a toggle and a held data bus from a foreign clock domain. Per channel, the block synchronises the toggle into `dst_clk`, detects each flip and captures the held bus. It then arbitrates round-robin between channels with pending captures and queues `{channel, data}` entries into a first-word-fall-through FIFO, which is drained with a valid/ready handshake. It replaces point-to-point single-channel crossings wherever several slow producers feed one consumer.

## Interface
- `WIDTH`, 8: data bits per channel.
- `CHANNELS`, 4: number of input channels, ≥1.
- `DEPTH`, 3: synchroniser stages per toggle, ≥2.
- `FIFO_DEPTH`, 4: output queue entries, power of two, ≥2.
- `dst_clk` in 1: the single clock; all state is in this domain.
- `dst_rst_n` in 1: asynchronous, active-low reset.
- `src_toggle` in CHANNELS: one toggle per channel, asynchronous.
- `src_bus` in CHANNELS*WIDTH: held buses, asynchronous, quasi-static; channel k is `[k*WIDTH +: WIDTH]`.
- `dst_valid` out 1: FIFO head is valid.
- `dst_ready` in 1: consumer accepts the head.
- `dst_bus` out WIDTH: head data.
- `dst_chan` out CW: head channel index. CW = max(1, clog2(CHANNELS)).
- `dst_overrun` out CHANNELS: sticky per-channel overrun flags.
- `dst_overrun_clr` in 1: clears all overrun flags.

## Operation
- Per channel:
  - Shift register `pipe[DEPTH-1:0]` samples `src_toggle[k]`.
  - `event[k]` = `pipe[DEPTH-1] != pipe[DEPTH-2]`.
  - On `event[k]`: `cap[k]` <= `src_bus` slice and `pending[k]` <= 1.
  - If `pending[k]` is already set and not granted in the same cycle: newest data wins, and `dst_overrun[k]` <= 1.
  - Event and grant on the same channel in the same cycle: the old capture is pushed, the new capture is loaded, `pending` stays 1, no overrun.
- Arbiter:
  - One grant per cycle among pending channels.
  - Search starts at `last+1` and wraps; `last` updates on grant.
  - Grant only when `push_ok` is true, i.e. FIFO not full, or FIFO full and a pop happens in the same cycle.
  - A grant pushes `{k, cap[k]}` and clears `pending[k]`.
- FIFO:
  - FWFT, with `FIFO_DEPTH` entries.
  - `dst_valid` = !empty; `dst_bus`/`dst_chan` show the head.
  - Pop when `dst_valid && dst_ready`.
  - Push and pop in the same cycle leave the count unchanged, including when full.
  - Read and write pointers wrap modulo `FIFO_DEPTH`.
  - Count width is clog2(FIFO_DEPTH)+1.
- Overrun clear: `dst_overrun_clr` clears all flags. If a set happens on the same cycle as the clear, set wins for that channel.
- Sender contract:
  - The hold bus updates on the same source edge as the toggle flip.
  - The hold bus stays stable for at least DEPTH+1 `dst_clk` cycles afterwards.
  - The sender resets its toggle to 0.
- Reset values (everything zero except `last`):
  - `pipe`, `pending`, `cap`, `dst_overrun`, FIFO pointers and count are all 0; `dst_valid` = 0.
  - `dst_bus` and `dst_chan` read 0.
  - `last` = CHANNELS-1, so channel 0 has priority first.
- Reset mid-operation: asynchronously discards pending captures and FIFO contents.
- If a toggle is 1 when reset releases, exactly one event is delivered for that channel. This is defined behaviour.

## Timing
- A toggle flip first sampled at edge 1:
  - `pipe[DEPTH-2]` changes after edge DEPTH-1.
  - `pending` is set at edge DEPTH.
  - The FIFO push happens at edge DEPTH+1.
  - `dst_valid` is high after edge DEPTH+1; for DEPTH=3, that is 4 cycles.
- Back-to-back grants: sustained 1 entry/cycle while the FIFO is not full.
- Arbitration latency for any channel is ≤ CHANNELS cycles once `push_ok` holds continuously.
- No combinational path from `dst_ready` to `dst_valid`.
- `dst_ready` → FIFO push enable is combinational; this is permitted.

## Structure
- No shared package is needed; CW and the count width are module-local localparams.
- Sub-module `cdc_rx_fifo` (WIDTH, DEPTH parameters): single-clock FWFT FIFO with push/pop/full/empty and asynchronous active-low reset.
- The synchroniser, capture and arbiter stay in `cdc_rx_mux`.

## Test plan
- **Single channel:** CHANNELS=4, DEPTH=3. Flip `src_toggle[2]` with bus 0x5A → after 4 edges `dst_valid`=1, `dst_chan`=2, `dst_bus`=0x5A; pop → `dst_valid`=0.
- **Simultaneous flips:** flip all 4 toggles on the same edge with data 0x10..0x13, `dst_ready`=1 → entries pop in order chan 0,1,2,3, one per cycle, with matching data.
- **Fairness:** hold `dst_ready`=0 and fill the FIFO (4 entries) → further grants stall. Release `dst_ready` with channels 1 and 3 pending, `last`=0 → channel 1 is granted before 3. A pop while full still allows a push that cycle.
- **Overrun:** with the FIFO full, flip channel 0 twice (0x01 then 0x02) → `dst_overrun[0]`=1, and the delivered data is 0x02 only. Pulse `dst_overrun_clr` → flag returns to 0; a clear coinciding with a new overrun leaves the flag 1.
- **Reset mid-operation:** assert `dst_rst_n` low mid-operation → `dst_valid`=0 immediately and all flags clear. With `src_toggle[1]`=1 at release → exactly one chan-1 entry is delivered.
